// File: rtl/srt_cmd_pkg.sv
// srt_cmd_pkg: shared command-entry type and marshalled-bus field layout.
package srt_cmd_pkg;
  localparam int CMD_ADDR_WIDTH = 8;
  localparam int CMD_DATA_WIDTH = 8;
  typedef struct packed {
    logic [CMD_ADDR_WIDTH-1:0] addr;
    logic [CMD_DATA_WIDTH-1:0] data;
  } cmd_entry_t;
  localparam int TOGGLE_BIT = CMD_ADDR_WIDTH + CMD_DATA_WIDTH;
  localparam int ADDR_LSB = CMD_DATA_WIDTH;
endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: synchronous FIFO; a push into a full queue succeeds when a pop frees a slot in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wrData,
  output logic [WIDTH-1:0]       rdData,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic doPush, doPop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign doPop = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign rdData = mem[rdPtr];
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + AW'(doPush);
      rdPtr <= rdPtr + AW'(doPop);
      count <= count + (AW+1)'(doPush) - (AW+1)'(doPop);
    end
  always_ff @(posedge clock)
    if (doPush) mem[wrPtr] <= wrData;
endmodule

// File: rtl/marshalled_write_receiver.sv
// marshalled_write_receiver: deskews the marshalled register-write bus and queues one command per toggle flip.
module marshalled_write_receiver
  import srt_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH    = CMD_ADDR_WIDTH,
  parameter int DATA_WIDTH    = CMD_DATA_WIDTH,
  parameter int FIFO_DEPTH    = 8,
  parameter int STABLE_CYCLES = 2
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [ADDR_WIDTH+DATA_WIDTH:0]  inBus,
  output logic                            cmdValid,
  output logic [ADDR_WIDTH-1:0]           cmdAddr,
  output logic [DATA_WIDTH-1:0]           cmdData,
  input  logic                            cmdReady,
  output logic [$clog2(FIFO_DEPTH):0]     fifoCount,
  output logic                            overflow,
  input  logic                            clearOverflow
);
  localparam int TOG = ADDR_WIDTH + DATA_WIDTH;
  localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SW-1:0] MAXC = SW'(STABLE_CYCLES - 1);
  logic [TOG:0] sample;
  logic [SW-1:0] stableCnt;
  logic lastToggle, accept, full, empty, drop;
  assign accept = stableCnt == MAXC && sample[TOG] != lastToggle;
  // A full queue still accepts when the consumer pops in the same cycle.
  assign drop = accept && full && !cmdReady;
  assign cmdValid = !empty;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sample <= '0;
      stableCnt <= '0;
      lastToggle <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sample <= inBus;
      stableCnt <= inBus != sample ? '0 : stableCnt == MAXC ? MAXC : stableCnt + 1'b1;
      lastToggle <= accept ? sample[TOG] : lastToggle;
      overflow <= drop ? 1'b1 : clearOverflow ? 1'b0 : overflow;
    end
  cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TOG)) fifo (
    .clock (clock),
    .reset (reset),
    .push  (accept),
    .pop   (cmdReady),
    .wrData(sample[TOG-1:0]),
    .rdData({cmdAddr, cmdData}),
    .full  (full),
    .empty (empty),
    .count (fifoCount)
  );
endmodule

// File: tb/tb_marshalled_write_receiver.sv
// tb_marshalled_write_receiver: directed vectors for the deskew filter, command queue and overflow flag.
module tb_marshalled_write_receiver;
  import srt_cmd_pkg::*;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [16:0] inBus = '0;
  logic cmdValid, cmdReady = 1'b0, overflow, clearOverflow = 1'b0;
  logic [7:0] cmdAddr, cmdData;
  logic [3:0] fifoCount;
  logic tgl = 1'b0;
  int nVec = 0, nBad = 0;
  cmd_entry_t expQ[$];
  cmd_entry_t e;

  marshalled_write_receiver dut (
    .clock(clock), .reset(reset), .inBus(inBus), .cmdValid(cmdValid),
    .cmdAddr(cmdAddr), .cmdData(cmdData), .cmdReady(cmdReady),
    .fifoCount(fifoCount), .overflow(overflow), .clearOverflow(clearOverflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] d);
    tgl = ~tgl;
    inBus = {tgl, a, d};
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    drive(a, d);
    repeat (3) tick();
  endtask

  task automatic popChk(input string tag);
    e = expQ.pop_front();
    chk({tag, "_valid"}, cmdValid, 1);
    chk({tag, "_head"}, {cmdAddr, cmdData}, e);
    cmdReady = 1'b1;
    tick();
    cmdReady = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (expQ.size() > 0) popChk(tag);
    chk({tag, "_empty"}, fifoCount, 0);
  endtask

  task automatic fill8(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      wr(base + 8'(i), 8'(i * 3 + 1));
      expQ.push_back({base + 8'(i), 8'(i * 3 + 1)});
    end
    chk("fill_count", fifoCount, 8);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_valid", cmdValid, 0);
    chk("rst_count", fifoCount, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();
    chk("idle_no_cmd", cmdValid, 0);

    drive(8'h21, 8'h5A);
    tick(); chk("lat_e1", cmdValid, 0);
    tick(); chk("lat_e2", cmdValid, 0);
    tick(); chk("lat_e3", cmdValid, 1);
    chk("lat_head", {cmdAddr, cmdData}, 16'h215A);
    chk("lat_count", fifoCount, 1);
    cmdReady = 1'b1; tick(); cmdReady = 1'b0;
    chk("pop_count", fifoCount, 0);
    chk("pop_valid", cmdValid, 0);

    drive(8'h21, 8'h00);
    tick();
    inBus[7:0] = 8'h5A;
    tick(); tick();
    chk("skew_e2", fifoCount, 0);
    tick();
    chk("skew_e3", fifoCount, 1);
    repeat (3) tick();
    chk("skew_once", fifoCount, 1);
    expQ.push_back({8'h21, 8'h5A});
    drain("skew");

    fill8(8'h40);
    wr(8'hEE, 8'hEE);
    chk("burst_full", fifoCount, 8);
    chk("burst_ovf", overflow, 1);
    drain("burst");
    chk("ovf_sticky", overflow, 1);
    clearOverflow = 1'b1; tick(); clearOverflow = 1'b0;
    chk("ovf_clear", overflow, 0);

    fill8(8'h80);
    drive(8'h99, 8'h66);
    tick(); tick();
    cmdReady = 1'b1; tick(); cmdReady = 1'b0;
    void'(expQ.pop_front());
    expQ.push_back({8'h99, 8'h66});
    chk("fp_ovf", overflow, 0);
    chk("fp_count", fifoCount, 8);
    drain("fullpop");

    fill8(8'hC0);
    drive(8'h11, 8'h22);
    tick(); tick();
    clearOverflow = 1'b1; tick();
    chk("ovf_set_wins", overflow, 1);
    tick(); clearOverflow = 1'b0;
    chk("ovf_clr_next", overflow, 0);
    drain("ovf");

    for (int i = 0; i < 3; i++) wr(8'(i), 8'(i));
    chk("pre_rst_count", fifoCount, 3);
    tgl = 1'b0; drive(8'h77, 8'h88);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", cmdValid, 0);
    chk("arst_count", fifoCount, 0);
    #3 reset = 1'b0;
    tick(); tick();
    chk("post_rst_e2", fifoCount, 0);
    tick();
    chk("post_rst_e3", fifoCount, 1);
    repeat (4) tick();
    chk("post_rst_once", fifoCount, 1);
    expQ.delete();
    expQ.push_back({8'h77, 8'h88});
    drain("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
